// File: rtl/episode_controller_5x5.sv
// Episode sequencer for the 5x5 grid: loads the map, then runs one environment step per accepted action.
// Latency: 3 cycles per step (RUN accept, EVAL sample, RESP present); map load 1 cell/cycle.
// Backpressure: res_valid holds until res_ready; step_ready is low outside RUN, so steps never overlap.
module episode_controller_5x5 #(
    parameter int LOCATION_LENGTH = 32,
    parameter int REWARD_LENGTH   = 11,
    parameter int MAP_SIZE        = 25,
    parameter int START_LOCATION  = 0,
    parameter int MAX_STEPS       = 100,
    parameter int STEP_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       map_valid,
    output logic                       map_ready,
    input  logic [1:0]                 map_data,
    input  logic                       start,
    input  logic                       step_valid,
    output logic                       step_ready,
    input  logic [1:0]                 step_action,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [REWARD_LENGTH-1:0]   res_reward,
    output logic [LOCATION_LENGTH-1:0] res_location,
    output logic                       res_done,
    output logic [LOCATION_LENGTH-1:0] env_current_location,
    output logic [1:0]                 env_action,
    output logic                       env_w_en,
    output logic [LOCATION_LENGTH-1:0] env_w_address,
    output logic [1:0]                 env_w_data,
    input  logic [REWARD_LENGTH-1:0]   env_reward,
    input  logic [LOCATION_LENGTH-1:0] env_next_location,
    output logic [LOCATION_LENGTH-1:0] location,
    output logic [STEP_WIDTH-1:0]      step_count,
    output logic [STEP_WIDTH-1:0]      episode_count
);

    typedef enum logic [2:0] {ST_LOAD, ST_WAIT, ST_RUN, ST_EVAL, ST_RESP} state_t;

    localparam logic [LOCATION_LENGTH-1:0] START_LOC   = LOCATION_LENGTH'(START_LOCATION);
    localparam logic [LOCATION_LENGTH-1:0] LAST_IDX    = LOCATION_LENGTH'(MAP_SIZE - 1);
    localparam logic [STEP_WIDTH-1:0]      STEP_LIMIT  = STEP_WIDTH'(MAX_STEPS);
    localparam logic [REWARD_LENGTH-1:0]   TREASURE_RW = {1'b0, {(REWARD_LENGTH-1){1'b1}}};

    state_t                     state;
    logic [LOCATION_LENGTH-1:0] load_idx;
    logic [STEP_WIDTH-1:0]      step_next;
    logic                       eval_done;

    // Map writes go straight through on the load handshake so the environment sees one beat per cycle.
    assign env_w_en             = map_valid & map_ready;
    assign env_w_address        = load_idx;
    assign env_w_data           = map_data;
    assign env_current_location = location;

    assign step_next = step_count + 1'b1;
    assign eval_done = (env_reward == TREASURE_RW) || (step_next == STEP_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_LOAD;
            load_idx      <= '0;
            map_ready     <= 1'b0;
            step_ready    <= 1'b0;
            res_valid     <= 1'b0;
            res_reward    <= '0;
            res_location  <= '0;
            res_done      <= 1'b0;
            env_action    <= 2'd0;
            location      <= START_LOC;
            step_count    <= '0;
            episode_count <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    map_ready <= 1'b1;
                    if (map_valid && map_ready) begin
                        load_idx <= load_idx + 1'b1;
                        if (load_idx == LAST_IDX) begin
                            map_ready <= 1'b0;
                            state     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (start) begin
                        step_ready <= 1'b1;
                        state      <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (step_valid && step_ready) begin
                        env_action <= step_action;
                        step_ready <= 1'b0;
                        state      <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    res_reward   <= env_reward;
                    res_location <= env_next_location;
                    res_done     <= eval_done;
                    res_valid    <= 1'b1;
                    // res_location reports where the step landed; location restarts the episode.
                    if (eval_done) begin
                        location      <= START_LOC;
                        step_count    <= '0;
                        episode_count <= episode_count + 1'b1;
                    end else begin
                        location   <= env_next_location;
                        step_count <= step_next;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        if (start) begin
                            step_ready <= 1'b1;
                            state      <= ST_RUN;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_episode_controller_5x5.sv
// Directed bench for episode_controller_5x5 with a behavioural 5x5 environment and a result scoreboard.
module tb_episode_controller_5x5;

    logic        clk = 1'b0;
    logic        reset;
    logic        map_valid, map_ready;
    logic [1:0]  map_data;
    logic        start, step_valid, step_ready;
    logic [1:0]  step_action;
    logic        res_valid, res_ready;
    logic [10:0] res_reward;
    logic [31:0] res_location;
    logic        res_done;
    logic [31:0] env_current_location;
    logic [1:0]  env_action;
    logic        env_w_en;
    logic [31:0] env_w_address;
    logic [1:0]  env_w_data;
    logic [10:0] env_reward;
    logic [31:0] env_next_location;
    logic [31:0] location;
    logic [15:0] step_count, episode_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [10:0] reward;
        logic [31:0] rloc;
        logic        done;
        logic [31:0] loc;
        logic [15:0] sc;
        logic [15:0] ec;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    episode_controller_5x5 #(.MAX_STEPS(3)) dut (
        .clk(clk), .reset(reset),
        .map_valid(map_valid), .map_ready(map_ready), .map_data(map_data),
        .start(start), .step_valid(step_valid), .step_ready(step_ready), .step_action(step_action),
        .res_valid(res_valid), .res_ready(res_ready), .res_reward(res_reward),
        .res_location(res_location), .res_done(res_done),
        .env_current_location(env_current_location), .env_action(env_action),
        .env_w_en(env_w_en), .env_w_address(env_w_address), .env_w_data(env_w_data),
        .env_reward(env_reward), .env_next_location(env_next_location),
        .location(location), .step_count(step_count), .episode_count(episode_count)
    );

    // Environment: border/wall/demon keep the agent in place; treasure 0x3FF, border/wall -2, demon -1023.
    logic [1:0] env_map [25];
    int cr, cc, nr, nc;
    always @(posedge clk) if (env_w_en && env_w_address < 32'd25) env_map[env_w_address[4:0]] <= env_w_data;
    always_comb begin
        cr = int'(env_current_location) / 5;
        cc = int'(env_current_location) % 5;
        nr = cr;
        nc = cc;
        case (env_action)
            2'd0: nc = cc - 1;
            2'd1: nr = cr - 1;
            2'd2: nc = cc + 1;
            default: nr = cr + 1;
        endcase
        env_next_location = env_current_location;
        env_reward        = 11'h7FE;
        if (nr >= 0 && nr < 5 && nc >= 0 && nc < 5) begin
            case (env_map[nr*5+nc])
                2'b00: begin env_next_location = 32'(nr*5+nc); env_reward = 11'h000; end
                2'b11: begin env_next_location = 32'(nr*5+nc); env_reward = 11'h3FF; end
                2'b10: env_reward = 11'h401;
                default: env_reward = 11'h7FE;
            endcase
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a result is consumed at the edge following a negedge with valid&ready.
    always @(negedge clk) begin
        if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_reward", res_reward, e.reward);
                chk("res_location", res_location, e.rloc);
                chk("res_done", res_done, e.done);
                chk("location", location, e.loc);
                chk("step_count", step_count, e.sc);
                chk("episode_count", episode_count, e.ec);
            end
        end
    end

    // Issues one action and checks EVAL/RESP timing; returns at the negedge of the first RESP cycle.
    task automatic do_step(input logic [1:0] act, input logic [10:0] r, input logic [31:0] rl,
                           input logic d, input logic [31:0] l, input logic [15:0] sc,
                           input logic [15:0] ec, input bit push);
        exp_t e;
        int   n;
        e.reward = r; e.rloc = rl; e.done = d; e.loc = l; e.sc = sc; e.ec = ec;
        if (push) sb.push_back(e);
        @(negedge clk);
        step_valid  = 1'b1;
        step_action = act;
        n = 0;
        while (!step_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("step_ready_wait", step_ready, 1);
        @(posedge clk);
        #1 step_valid = 1'b0;
        @(negedge clk);
        chk("res_valid_in_eval", res_valid, 0);
        chk("step_ready_in_eval", step_ready, 0);
        @(negedge clk);
        chk("res_valid_in_resp", res_valid, 1);
    endtask

    initial begin
        int n;
        reset = 1'b1; map_valid = 1'b0; map_data = 2'b00; start = 1'b0;
        step_valid = 1'b0; step_action = 2'd0; res_ready = 1'b1;
        #1;
        chk("rst_map_ready", map_ready, 0);
        chk("rst_step_ready", step_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_location", location, 0);
        chk("rst_episode_count", episode_count, 0);
        @(negedge clk);
        reset = 1'b0;

        n = 0;
        while (!map_ready && n < 20) begin @(negedge clk); n++; end
        chk("load_map_ready", map_ready, 1);
        for (int i = 0; i < 25; i++) begin
            map_valid = 1'b1;
            map_data  = (i == 6) ? 2'b11 : 2'b00;
            #1;
            chk("w_en", env_w_en, 1);
            chk("w_address", env_w_address, 64'(i));
            chk("w_data", env_w_data, (i == 6) ? 2'b11 : 2'b00);
            @(negedge clk);
        end
        map_valid = 1'b0;
        chk("wait_map_ready", map_ready, 0);
        step_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("wait_step_ready", step_ready, 0);
        end
        step_valid = 1'b0;
        start = 1'b1;

        do_step(2'd2, 11'h000, 32'd1, 1'b0, 32'd1, 16'd1, 16'd0, 1'b1);  // RIGHT 0->1
        do_step(2'd3, 11'h3FF, 32'd6, 1'b1, 32'd0, 16'd0, 16'd1, 1'b1);  // DOWN into treasure
        do_step(2'd1, 11'h7FE, 32'd0, 1'b0, 32'd0, 16'd1, 16'd1, 1'b1);  // UP at border
        do_step(2'd1, 11'h7FE, 32'd0, 1'b0, 32'd0, 16'd2, 16'd1, 1'b1);
        do_step(2'd1, 11'h7FE, 32'd0, 1'b1, 32'd0, 16'd0, 16'd2, 1'b1);  // step budget of 3 hit
        do_step(2'd0, 11'h7FE, 32'd0, 1'b0, 32'd0, 16'd1, 16'd2, 1'b1);  // LEFT at border
        start = 1'b0;

        @(negedge clk);
        step_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stopped_step_ready", step_ready, 0);
        end
        step_valid = 1'b0;
        start = 1'b1;

        res_ready = 1'b0;
        do_step(2'd2, 11'h000, 32'd1, 1'b0, 32'd1, 16'd2, 16'd2, 1'b1);
        repeat (5) begin
            @(negedge clk);
            chk("hold_res_valid", res_valid, 1);
            chk("hold_res_reward", res_reward, 11'h000);
            chk("hold_res_location", res_location, 32'd1);
            chk("hold_res_done", res_done, 0);
            chk("hold_step_ready", step_ready, 0);
        end
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;

        do_step(2'd1, 11'h7FE, 32'd1, 1'b1, 32'd0, 16'd0, 16'd3, 1'b0);
        chk("pre_reset_episode_count", episode_count, 3);
        reset = 1'b1;
        #1;
        chk("abort_res_valid", res_valid, 0);
        chk("abort_res_reward", res_reward, 0);
        chk("abort_res_location", res_location, 0);
        chk("abort_res_done", res_done, 0);
        chk("abort_step_ready", step_ready, 0);
        chk("abort_map_ready", map_ready, 0);
        chk("abort_location", location, 0);
        chk("abort_step_count", step_count, 0);
        chk("abort_episode_count", episode_count, 0);
        chk("abort_env_action", env_action, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reload_map_ready", map_ready, 1);
        chk("scoreboard_empty", 64'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/episode_controller_5x5.md
# episode_controller_5x5

Sequencer that owns the 5x5 grid environment: it loads the 25-cell map, holds the agent's current location, and runs one environment step per accepted action. It reports reward, next location and episode-done through a valid/ready result channel. It sits between the Dyna-Q agent/scheduler and `enviroment_5x5`. It restarts episodes at a fixed start cell when the treasure is reached or the step budget expires.

## Interface
- LOCATION_LENGTH, 32, location/address width (matches environment)
- REWARD_LENGTH, 11, signed reward width
- MAP_SIZE, 25, number of map cells loaded
- START_LOCATION, 0, cell each episode starts from
- MAX_STEPS, 100, step budget per episode (>=1)
- STEP_WIDTH, 16, width of step/episode counters
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- map_valid  in  1  map cell beat valid
- map_ready  out  1  controller accepts map cell
- map_data  in  2  cell code {00 empty, 01 wall, 10 demon, 11 treasure}
- start  in  1  level; begin episodes once map loaded
- step_valid  in  1  agent presents action
- step_ready  out  1  controller accepts action
- step_action  in  2  {0 LEFT, 1 UP, 2 RIGHT, 3 DOWN}
- res_valid  out  1  step result valid
- res_ready  in  1  agent accepts result
- res_reward  out  REWARD_LENGTH  reward of the step
- res_location  out  LOCATION_LENGTH  location after the step (before episode restart)
- res_done  out  1  this step ended the episode
- env_current_location  out  LOCATION_LENGTH  to environment
- env_action  out  2  to environment
- env_w_en  out  1  map write strobe
- env_w_address  out  LOCATION_LENGTH  map write address
- env_w_data  out  2  map write data
- env_reward  in  REWARD_LENGTH  from environment (combinational)
- env_next_location  in  LOCATION_LENGTH  from environment (combinational)
- location  out  LOCATION_LENGTH  registered current location
- step_count  out  STEP_WIDTH  steps taken in current episode
- episode_count  out  STEP_WIDTH  completed episodes, wraps at 2^STEP_WIDTH

## Operation
- FSM states: LOAD, WAIT, RUN, EVAL, RESP.
- Reset values: state=LOAD, location=START_LOCATION, counters=0, load index=0, all valid/ready/strobe outputs 0, res_* registers 0.
- LOAD: map_ready=1. On each map_valid&map_ready, pulse env_w_en for that cycle, with env_w_address=index and env_w_data=map_data, then increment index. When beat MAP_SIZE-1 is accepted, go to WAIT.
- WAIT: when start=1, go to RUN.
- RUN: step_ready=1. On handshake, latch the action into env_action and go to EVAL. env_current_location always equals location.
- EVAL: sample env_reward/env_next_location into res_reward/res_location and increment step_count.
  - done = (env_reward == {0,1...1}, the treasure reward) OR (step_count+1 == MAX_STEPS).
  - If done: location<=START_LOCATION, step_count<=0, episode_count+1.
  - Else: location<=env_next_location.
  - Go to RESP.
- RESP: res_valid=1 with stable res_*. On res_ready, go to RUN, or to WAIT if start=0.
- Wall, demon and border moves are ordinary steps: location unchanged, reward passed through, step counted.
- env_w_en is 0 outside LOAD. Reloading the map requires reset.

## Timing
- Map load: one cell per cycle at full rate; WAIT is entered the cycle after the last beat.
- Step latency: action accepted at edge N, EVAL during cycle N+1, res_valid high from cycle N+2. Minimum 3 cycles per step with res_ready held high.
- res_valid holds until accepted. step_ready is 0 in every state except RUN, so there is no overlap between steps.
- Reset asserted in any state aborts immediately. A partial map load stays in the environment map and is overwritten by the next load.
- step_valid in LOAD/WAIT is ignored (not accepted).

## Test plan
- Load 25 cells (all 00 except cell 6 = 11), start=1 -> env_w_en pulses 25 times at addresses 0..24, then step_ready=1.
- From 0, action RIGHT -> res_location=1, res_reward=0, res_done=0, location=1, step_count=1, res_valid 2 cycles after the step handshake.
- From 1, action DOWN into treasure cell 6 -> res_reward=0x3FF, res_location=6, res_done=1, location=0, step_count=0, episode_count=1.
- From 0, action LEFT (border) -> res_reward=-2 (0x7FE), location stays 0.
- MAX_STEPS=3, three UP actions at location 0 -> third result has res_done=1 and episode_count increments.
- Hold res_ready=0 for 5 cycles -> res_* stable, step_ready=0. Assert reset mid-RESP -> all outputs at reset values, state LOAD.
